uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Byte FIFO directly downstream of the UART receiver. It absorbs received characters so the CPU's memory-mapped UART read path can fall behind by up to DEPTH bytes without losing data. The input side always accepts. When full, an arriving byte is dropped, and the drop is recorded in a sticky overrun flag and a saturating counter. The output side is a first-word-fall-through ready/valid interface to the MMIO read logic.

## Interface
- DEPTH, 8: entries; power of two, 2..256
- DROP_W, 8: width of drop counter
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_data  in  8  byte from receiver
- in_valid  in  1  byte present
- in_ready  out  1  always 1 (reset value 1); the receiver's byte is consumed every cycle in_valid=1
- out_data  out  8  head byte; valid only while out_valid=1
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer takes head
- count  out  $clog2(DEPTH)+1  current occupancy
- full  out  1  count==DEPTH
- overrun  out  1  sticky; set on any dropped byte
- drop_count  out  DROP_W  dropped bytes, saturating at all-ones
- clear_overrun  in  1  synchronous pulse; clears overrun and drop_count

## Operation
- push = in_valid & (~full | pop); pop = out_valid & out_ready.
- push: mem[wr_ptr] <= in_data; wr_ptr increments.
- pop: rd_ptr increments.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
- count = wr_ptr - rd_ptr (modulo width); empty when count==0; full when count==DEPTH.
- Simultaneous push and pop:
  - When full: the pop frees the slot, the push is accepted, count is unchanged, no drop.
  - When empty: only the push happens, since out_valid=0 means no pop.
- Drop: in_valid & full & ~pop.
  - overrun <= 1.
  - drop_count increments unless already all-ones.
  - Storage and pointers are unchanged.
- clear_overrun in the same cycle as a drop: clear wins. Next state is overrun=0 and drop_count=0, and that dropped byte is not counted.
- out_data = mem[rd_ptr[low bits]] combinationally (FWFT). The head is stable while out_valid=1 and out_ready=0.
- reset_n low, asynchronously:
  - Pointers, count, overrun and drop_count clear to 0.
  - out_valid=0, full=0.
  - Memory contents are not reset.
  - Bytes in flight are discarded.

## Timing
- Push-to-output latency: 1 cycle. A byte written at edge N shows out_valid=1 and out_data after edge N.
- Pop takes effect at the edge where out_valid & out_ready; the next head appears after that edge.
- All outputs are registers, or combinational from pointers and memory only. There is no combinational path from in_valid or out_ready to any output.
- Full and simultaneous push/pop throughput: 1 byte/cycle in and out.
- Reset deassertion is synchronised externally. The block does not require any delay after reset release.

## Structure
- Shared package uart_pkg:
  - UART_DATA_W = 8.
  - Function for pointer width ($clog2(DEPTH)+1).
- Sub-module fifo_mem:
  - DEPTH x 8 register array.
  - Synchronous write port (we, waddr, wdata), asynchronous read port (raddr, rdata).
  - Reusable by a later uart_tx_fifo.
- Top level holds the pointers, flag/counter logic and output assigns.

## Test plan
- Reset then single byte: push 0xA5 -> next cycle out_valid=1, out_data=0xA5, count=1. Pop with out_ready=1 -> out_valid=0, count=0.
- Fill and order: push 0x00..0x07 with out_ready=0 -> full=1, count=8. Drain -> bytes emerge 0x00..0x07 in order, then empty.
- Overflow: with FIFO full, push 3 more bytes (0x10,0x11,0x12) with out_ready=0 ->
  - overrun=1, drop_count=3.
  - Drained contents still 0x00..0x07.
  - clear_overrun -> both 0.
- Full with simultaneous push/pop: full FIFO, out_ready=1 and in_valid=1 (0x55) for one cycle ->
  - count stays 8, no drop.
  - 0x55 emerges last after draining.
- Saturation and clear collision:
  - 300 drops with DROP_W=8 -> drop_count=255.
  - Drop coincident with clear_overrun -> overrun=0, drop_count=0.
- Async reset mid-stream: assert reset_n low between clock edges with count=5 -> count=0, out_valid=0, overrun=0 immediately, without waiting for a clock edge. After release, pushing 0x3C yields 0x3C as the head.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and FIFO pointer sizing helper.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // Pointer width for a power-of-two FIFO: one extra bit separates full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Generic FIFO storage: register array with a synchronous write port and an
// asynchronous read port so the head can be presented first-word-fall-through.
// Contents are deliberately not reset.
module fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write the incoming word into the addressed slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the MMIO read path.
// The input always accepts; bytes arriving while full are dropped and
// recorded in a sticky overrun flag and a saturating drop counter.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [UART_DATA_W-1:0]    in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [UART_DATA_W-1:0]    out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      overrun,
    output logic [DROP_W-1:0]         drop_count,
    input  logic                      clear_overrun
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int AW    = PTR_W - 1;

    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [PTR_W-1:0]       count_s;
    logic                   full_s;
    logic                   out_valid_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   drop_s;
    logic                   in_ready_r;
    logic                   overrun_r;
    logic [DROP_W-1:0]      drop_count_r;
    logic [UART_DATA_W-1:0] rdata_s;

    // Occupancy and handshake decode, all derived from registered pointers.
    always_comb begin
        count_s     = wr_ptr_r - rd_ptr_r;
        full_s      = (count_s == PTR_W'(DEPTH));
        out_valid_s = (count_s != {PTR_W{1'b0}});
        pop_s       = out_valid_s & out_ready;
        push_s      = in_valid & (~full_s | pop_s);
        drop_s      = in_valid & full_s & ~pop_s;
    end

    // Advance write/read pointers on accepted push and pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
        end
    end

    // Sticky overrun flag and saturating drop counter; clear has priority over a drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_r    <= 1'b0;
            drop_count_r <= {DROP_W{1'b0}};
        end else if (clear_overrun) begin
            overrun_r    <= 1'b0;
            drop_count_r <= {DROP_W{1'b0}};
        end else if (drop_s) begin
            overrun_r <= 1'b1;
            if (drop_count_r != {DROP_W{1'b1}}) begin
                drop_count_r <= drop_count_r + DROP_W'(1'b1);
            end
        end
    end

    // Input side never back-pressures; held as a register so it is 1 from reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_r <= 1'b1;
        end else begin
            in_ready_r <= 1'b1;
        end
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr_r[AW-1:0]),
        .rdata (rdata_s)
    );

    assign in_ready   = in_ready_r;
    assign out_data   = rdata_s;
    assign out_valid  = out_valid_s;
    assign count      = count_s;
    assign full       = full_s;
    assign overrun    = overrun_r;
    assign drop_count = drop_count_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=8, DROP_W=8).
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] count;
    logic       full;
    logic       overrun;
    logic [7:0] drop_count;
    logic       clear_overrun;

    int total;
    int bad;

    uart_rx_fifo #(
        .DEPTH  (8),
        .DROP_W (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .count         (count),
        .full          (full),
        .overrun       (overrun),
        .drop_count    (drop_count),
        .clear_overrun (clear_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock; inputs and checks happen 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset_n       = 1'b0;
        in_data       = 8'h00;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        clear_overrun = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;
        tick();

        // Single byte through.
        push(8'hA5);
        chk("one_valid", 32'(out_valid), 32'd1);
        chk("one_data", 32'(out_data), 32'hA5);
        chk("one_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("one_pop_valid", 32'(out_valid), 32'd0);
        chk("one_pop_count", 32'(count), 32'd0);

        // Fill, overflow, drain in order, clear.
        for (int i = 0; i < 8; i++) push(8'(i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_ready", 32'(in_ready), 32'd1);
        push(8'h10);
        push(8'h11);
        push(8'h12);
        chk("ovf_flag", 32'(overrun), 32'd1);
        chk("ovf_drops", 32'(drop_count), 32'd3);
        chk("ovf_count", 32'(count), 32'd8);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_data", 32'(out_data), 32'(i));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("drain_count", 32'(count), 32'd0);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("clr_flag", 32'(overrun), 32'd0);
        chk("clr_drops", 32'(drop_count), 32'd0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
        in_valid  = 1'b1;
        in_data   = 8'h55;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pp_count", 32'(count), 32'd8);
        chk("pp_full", 32'(full), 32'd1);
        chk("pp_ovr", 32'(overrun), 32'd0);
        chk("pp_drops", 32'(drop_count), 32'd0);
        out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            chk("pp_drain", 32'(out_data), 32'h20 + 32'(i));
            tick();
        end
        chk("pp_last", 32'(out_data), 32'h55);
        tick();
        out_ready = 1'b0;
        chk("pp_empty", 32'(out_valid), 32'd0);

        // Saturation and clear/drop collision.
        for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int i = 0; i < 300; i++) tick();
        chk("sat_drops", 32'(drop_count), 32'd255);
        chk("sat_flag", 32'(overrun), 32'd1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        in_valid      = 1'b0;
        chk("coll_flag", 32'(overrun), 32'd0);
        chk("coll_drops", 32'(drop_count), 32'd0);
        push(8'hEF);
        chk("post_drop1", 32'(drop_count), 32'd1);
        chk("sat_head", 32'(out_data), 32'h40);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        out_ready = 1'b0;
        chk("sat_empty", 32'(out_valid), 32'd0);

        // Async reset mid-stream with count=5 and overrun set.
        for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
        push(8'h99);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b0;
        chk("ar_pre_count", 32'(count), 32'd5);
        chk("ar_pre_ovr", 32'(overrun), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_ovr", 32'(overrun), 32'd0);
        chk("ar_drops", 32'(drop_count), 32'd0);
        chk("ar_full", 32'(full), 32'd0);
        tick();
        reset_n = 1'b1;
        push(8'h3C);
        chk("ar_new_valid", 32'(out_valid), 32'd1);
        chk("ar_new_data", 32'(out_data), 32'h3C);
        chk("ar_new_count", 32'(count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
